// File: rtl/cordic_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_sequencer                                           |
// | Description : Sequences one angle request through an external angle      |
// |               normalizer and an iterative CORDIC core, then holds the    |
// |               raw sin/cos results plus the quadrant flip code for a      |
// |               downstream result converter (valid/ready handshake).       |
// | Options     : CORDIC_SEQ_TIMEOUT_EN - bounds the wait for core_done to   |
// |               TIMEOUT cycles and raises a sticky err_timeout on expiry.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cordic_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_angle,
  output logic [WIDTH-1:0] norm_angle_in,
  input  logic [WIDTH-1:0] norm_angle_out,
  input  logic [2:0]       norm_flip,
  output logic             core_start,
  output logic [WIDTH-1:0] core_angle,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_sin,
  input  logic [WIDTH-1:0] core_cos,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sin,
  output logic [WIDTH-1:0] res_cos,
  output logic [2:0]       res_flip,
  output logic             err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_angle;
  logic [2:0]       r_flip;
  logic             r_req_ready;
  logic             r_core_start;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_sin;
  logic [WIDTH-1:0] r_res_cos;
  logic [2:0]       r_res_flip;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err_timeout;
  logic             w_timeout_hit;

  // Last permitted WAIT cycle: a core_done arriving here still wins.
  assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err_timeout   = r_err_timeout;
`else
  logic w_unused_timeout;

  // Without the watchdog the wait is unbounded and the flag never rises.
  assign w_unused_timeout = (TIMEOUT != 0);
  assign err_timeout      = 1'b0;
`endif

  // The normalizer sees the latched request; the core sees the normalizer.
  assign norm_angle_in = r_angle;
  assign core_angle    = norm_angle_out;

  assign req_ready  = r_req_ready;
  assign core_start = r_core_start;
  assign res_valid  = r_res_valid;
  assign res_sin    = r_res_sin;
  assign res_cos    = r_res_cos;
  assign res_flip   = r_res_flip;

  // Sequencer FSM with all outputs registered; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_angle      <= '0;
      r_flip       <= '0;
      r_req_ready  <= 1'b1;
      r_core_start <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_sin    <= '0;
      r_res_cos    <= '0;
      r_res_flip   <= '0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_angle      <= req_angle;
            r_req_ready  <= 1'b0;
            r_core_start <= 1'b1;
            r_state      <= ST_START;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif
          end
        end

        ST_START: begin
          // Normalizer has had a full cycle on angle_q; its flip code is settled.
          r_core_start <= 1'b0;
          r_flip       <= norm_flip;
          r_state      <= ST_WAIT;
`ifdef CORDIC_SEQ_TIMEOUT_EN
          r_wait_cnt   <= '0;
`endif
        end

        ST_WAIT: begin
          if (core_done) begin
            r_res_sin   <= core_sin;
            r_res_cos   <= core_cos;
            r_res_flip  <= r_flip;
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
`ifdef CORDIC_SEQ_TIMEOUT_EN
          else if (w_timeout_hit) begin
            // Give up: previous results stay visible but are not re-validated.
            r_err_timeout <= 1'b1;
            r_req_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end

        ST_HOLD: begin
          // req_ready rises with the move to IDLE, so the exit cycle never accepts.
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cordic_sequencer                                        |
// | Description : Self-checking bench for cordic_sequencer. Models the       |
// |               normalizer as angle -> (angle mod 8192, angle / 8192) and  |
// |               drives core_done/sin/cos directly. Timeout scenarios are   |
// |               compiled in with CORDIC_SEQ_TIMEOUT_EN.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cordic_sequencer;

  localparam int W   = 16;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_angle;
  logic [W-1:0]  norm_angle_in;
  logic [W-1:0]  norm_angle_out;
  logic [2:0]    norm_flip;
  logic          core_start;
  logic [W-1:0]  core_angle;
  logic          core_done;
  logic [W-1:0]  core_sin;
  logic [W-1:0]  core_cos;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_sin;
  logic [W-1:0]  res_cos;
  logic [2:0]    res_flip;
  logic          err_timeout;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] last_sin;
  logic [W-1:0] last_cos;
  logic [2:0]   last_flip;

  cordic_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_angle     (req_angle),
    .norm_angle_in (norm_angle_in),
    .norm_angle_out(norm_angle_out),
    .norm_flip     (norm_flip),
    .core_start    (core_start),
    .core_angle    (core_angle),
    .core_done     (core_done),
    .core_sin      (core_sin),
    .core_cos      (core_cos),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sin       (res_sin),
    .res_cos       (res_cos),
    .res_flip      (res_flip),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  // Reference model of the normalizer: residue within an octant and octant index.
  function automatic logic [W-1:0] ref_core(input logic [W-1:0] a);
    return a % 16'd8192;
  endfunction

  function automatic logic [2:0] ref_flip(input logic [W-1:0] a);
    return 3'(a / 16'd8192);
  endfunction

  assign norm_angle_out = ref_core(norm_angle_in);
  assign norm_flip      = ref_flip(norm_angle_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request: handshake, start, wait 'delay' cycles, hold for 'bp' cycles.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] s, input logic [W-1:0] c,
                         input int delay, input int bp, input logic [2:0] eflip,
                         input logic [W-1:0] ecore);
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_angle = a;
    tick();
    req_valid = 1'b0;
    req_angle = W'($urandom);
    check("start_pulse", core_start, 1);
    check("start_norm_in", norm_angle_in, a);
    check("start_core_angle", core_angle, ecore);
    check("start_req_ready", req_ready, 0);
    tick();
    check("start_one_cycle", core_start, 0);
    for (int i = 1; i < delay; i++) tick();
    check("wait_no_valid", res_valid, 0);
    check("wait_core_angle", core_angle, ecore);
    core_done = 1'b1;
    core_sin  = s;
    core_cos  = c;
    tick();
    core_done = 1'b0;
    core_sin  = W'($urandom);
    core_cos  = W'($urandom);
    check("hold_valid", res_valid, 1);
    check("hold_sin", res_sin, s);
    check("hold_cos", res_cos, c);
    check("hold_flip", res_flip, eflip);
    check("hold_req_ready", req_ready, 0);
    for (int i = 0; i < bp; i++) begin
      core_done = (i == 0);
      tick();
      core_done = 1'b0;
      check("bp_valid", res_valid, 1);
      check("bp_sin", res_sin, s);
      check("bp_cos", res_cos, c);
      check("bp_flip", res_flip, eflip);
      check("bp_req_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("exit_valid", res_valid, 0);
    check("exit_req_ready", req_ready, 1);
    check("exit_no_start", core_start, 0);
    check("exit_sin_kept", res_sin, s);
    last_sin  = s;
    last_cos  = c;
    last_flip = eflip;
  endtask

  typedef struct {
    logic [W-1:0] angle;
    logic [W-1:0] sin;
    logic [W-1:0] cos;
    int           delay;
    int           bp;
    logic [2:0]   flip;
    logic [W-1:0] core;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, s, c;
    int bad_valid;
    int bad_start;

    vecs[0] = '{16'h2000, 16'h1234, 16'h5678, 16, 0,  3'b001, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'h8001, 16'h7FFF, 1,  10, 3'b111, 16'h1FFF};
    vecs[2] = '{16'h6ABC, 16'h0F0F, 16'hF0F0, 3,  2,  3'b011, 16'h0ABC};
    vecs[3] = '{16'h9555, 16'hDEAD, 16'hBEEF, 7,  1,  3'b100, 16'h1555};

    rst_n = 1'b0; req_valid = 1'b0; req_angle = '0; core_done = 1'b0;
    core_sin = '0; core_cos = '0; res_ready = 1'b0;
    last_sin = '0; last_cos = '0; last_flip = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sin", res_sin, 0);
    check("rst_norm_in", norm_angle_in, 0);
    check("rst_err", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_no_start", core_start, 0);

    // Spurious done in IDLE
    core_done = 1'b1; core_sin = 16'h1111; core_cos = 16'h2222;
    repeat (3) tick();
    core_done = 1'b0;
    check("idle_done_ready", req_ready, 1);
    check("idle_done_valid", res_valid, 0);
    check("idle_done_start", core_start, 0);
    check("idle_done_sin", res_sin, 0);

    // Table-driven transactions
    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].angle, vecs[i].sin, vecs[i].cos, vecs[i].delay, vecs[i].bp,
              vecs[i].flip, vecs[i].core);

    // Spurious done in IDLE after a result: nothing captured
    core_done = 1'b1; core_sin = 16'h3333; core_cos = 16'h4444;
    tick();
    core_done = 1'b0;
    check("idle2_sin", res_sin, last_sin);
    check("idle2_cos", res_cos, last_cos);
    check("idle2_valid", res_valid, 0);

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_angle = 16'h4321;
    tick();
    check("b2b_start1", core_start, 1);
    check("b2b_norm1", norm_angle_in, 16'h4321);
    tick();
    core_done = 1'b1; core_sin = 16'h0101; core_cos = 16'h0202;
    tick();
    core_done = 1'b0;
    check("b2b_hold1", res_valid, 1);
    check("b2b_flip1", res_flip, 3'b010);
    res_ready = 1'b1; req_angle = 16'hC0DE;
    tick();
    res_ready = 1'b0;
    check("b2b_exit_valid", res_valid, 0);
    check("b2b_exit_nostart", core_start, 0);
    check("b2b_exit_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("b2b_start2", core_start, 1);
    check("b2b_norm2", norm_angle_in, 16'hC0DE);
    tick();
    core_done = 1'b1; core_sin = 16'h0303; core_cos = 16'h0404;
    tick();
    core_done = 1'b0;
    check("b2b_flip2", res_flip, 3'b110);
    check("b2b_sin2", res_sin, 16'h0303);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("b2b_done_ready", req_ready, 1);

    // Reset while in WAIT
    req_valid = 1'b1; req_angle = 16'hA5A5;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_req_ready", req_ready, 1);
    check("rw_start", core_start, 0);
    check("rw_valid", res_valid, 0);
    check("rw_sin", res_sin, 0);
    check("rw_cos", res_cos, 0);
    check("rw_flip", res_flip, 0);
    check("rw_norm_in", norm_angle_in, 0);
    check("rw_core_angle", core_angle, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sin = '0; last_cos = '0; last_flip = '0;
    bad_valid = 0; bad_start = 0;
    core_done = 1'b1; core_sin = 16'h5555; core_cos = 16'h6666;
    for (int i = 0; i < 6; i++) begin
      tick();
      core_done = 1'b0;
      if (res_valid !== 1'b0) bad_valid++;
      if (core_start !== 1'b0) bad_start++;
    end
    check("rw_late_done_valid", bad_valid, 0);
    check("rw_no_start", bad_start, 0);
    check("rw_sin_clear", res_sin, 0);

    // Randomized transactions against the reference model
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      s = W'($urandom);
      c = W'($urandom);
      run_txn(a, s, c, $urandom_range(1, 12), $urandom_range(0, 3), ref_flip(a), ref_core(a));
    end

`ifdef CORDIC_SEQ_TIMEOUT_EN
    // Done on the last permitted WAIT cycle counts as completion
    run_txn(16'h3C3C, 16'h7777, 16'h8888, TMO, 0, ref_flip(16'h3C3C), ref_core(16'h3C3C));
    check("tmo_edge_err", err_timeout, 0);

    // No done: timeout TMO cycles after WAIT entry
    req_valid = 1'b1; req_angle = 16'h1357;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 1; i < TMO; i++) tick();
    check("tmo_still_wait", req_ready, 0);
    check("tmo_no_err_yet", err_timeout, 0);
    tick();
    check("tmo_err", err_timeout, 1);
    check("tmo_idle", req_ready, 1);
    check("tmo_no_valid", res_valid, 0);
    check("tmo_sin_kept", res_sin, last_sin);
    check("tmo_flip_kept", res_flip, last_flip);
    tick();
    check("tmo_sticky", err_timeout, 1);
    req_valid = 1'b1; req_angle = 16'h0042;
    tick();
    req_valid = 1'b0;
    check("tmo_cleared", err_timeout, 0);
    tick();
    core_done = 1'b1; core_sin = 16'h0A0A; core_cos = 16'h0B0B;
    tick();
    core_done = 1'b0;
    check("tmo_after_sin", res_sin, 16'h0A0A);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`else
    check("no_tmo_err", err_timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the angle and sample width in bits.
REQ-002 The module SHALL have parameter TIMEOUT, default 32, giving the maximum number of cycles spent waiting for core_done.
REQ-003 The port list SHALL be as follows (name  direction  width  meaning):
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  an angle request is offered.
- req_ready  out  1  the sequencer accepts a request.
- req_angle  in  WIDTH  raw signed angle.
- norm_angle_in  out  WIDTH  registered angle driven to the normalizer.
- norm_angle_out  in  WIDTH  normalized angle from the normalizer.
- norm_flip  in  3  signed quadrant flip code from the normalizer.
- core_start  out  1  one-cycle start pulse to the CORDIC core.
- core_angle  out  WIDTH  angle operand for the CORDIC core.
- core_done  in  1  the CORDIC core has finished.
- core_sin, core_cos  in  WIDTH each  raw signed CORDIC results.
- res_valid  out  1  a result is held for the result converter.
- res_ready  in  1  downstream accepts the result.
- res_sin, res_cos  out  WIDTH each  captured raw results.
- res_flip  out  3  captured flip code.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-004 The sequencer SHALL implement the states IDLE, START, WAIT and HOLD, with IDLE as the reset state.
REQ-005 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready sampled at a rising edge.
REQ-006 On a handshake, the sequencer SHALL latch req_angle into angle_q, clear err_timeout and move IDLE -> START.
REQ-007 norm_angle_in SHALL equal angle_q at all times.
REQ-008 core_angle SHALL equal norm_angle_out combinationally, and therefore stay stable from START through WAIT.
REQ-009 In START, core_start SHALL be 1 for exactly one cycle, norm_flip SHALL be latched into flip_q, and the next state SHALL be WAIT.
REQ-010 In WAIT, when core_done = 1, the sequencer SHALL latch core_sin and core_cos into res_sin and res_cos, drive res_flip from flip_q, and move to HOLD.
REQ-011 core_done SHALL be ignored in every state other than WAIT.
REQ-012 In HOLD, res_valid SHALL be 1 and res_sin, res_cos and res_flip SHALL be stable; when res_ready = 1 at an edge, the next state SHALL be IDLE.
REQ-013 Latency SHALL be: handshake at edge N gives core_start high in cycle N+1; core_done high in cycle M gives res_valid high from cycle M+1.
REQ-014 A new request SHALL NOT be accepted in the cycle in which HOLD exits; req_ready rises one cycle later, in IDLE.
REQ-015 The flip code SHALL be passed through unmodified; the sign conversion is done downstream, not in this block.

Reset
REQ-016 While rst_n = 0, the state SHALL be IDLE and all outputs SHALL be 0 except req_ready, which SHALL be 1.
REQ-017 Assertion of rst_n mid-operation SHALL abandon the operation immediately, with no partial result presented.
REQ-018 After rst_n deasserts, no core_start SHALL be issued until a new handshake occurs.

Configuration
REQ-019 With macro CORDIC_SEQ_TIMEOUT_EN defined, a cycle counter SHALL count cycles spent in WAIT, starting at 0 on entry.
REQ-020 With CORDIC_SEQ_TIMEOUT_EN defined, if the counter reaches TIMEOUT-1 with core_done = 0, the sequencer SHALL set err_timeout, leave all res_* outputs unchanged and move to IDLE.
REQ-021 With CORDIC_SEQ_TIMEOUT_EN defined, core_done = 1 in the cycle the counter reaches TIMEOUT-1 SHALL count as completion, not timeout.
REQ-022 Without CORDIC_SEQ_TIMEOUT_EN, WAIT SHALL persist until core_done, no counter SHALL be implemented, and err_timeout SHALL be tied to 0.

Verification
REQ-023 Normal operation: angle 0x2000, normalizer flip 3'b001, core_done 16 cycles after core_start with sin = 0x1234 and cos = 0x5678 -> res_valid one cycle later with res_sin = 0x1234, res_cos = 0x5678, res_flip = 3'b001.
REQ-024 Backpressure: res_ready held 0 for 10 cycles -> res_valid and all res_* stay stable and req_ready stays 0; res_ready = 1 -> IDLE, and req_ready = 1 in the following cycle.
REQ-025 Spurious done: core_done pulses while in IDLE and HOLD -> no state change and no result capture.
REQ-026 Reset in WAIT: rst_n pulsed low -> all outputs 0, req_ready = 1, and a later core_done produces no res_valid.
REQ-027 Timeout with the macro defined: TIMEOUT = 8 and no core_done -> err_timeout = 1 and return to IDLE 8 cycles after WAIT entry; the next handshake clears err_timeout.
REQ-028 Back-to-back requests: req_valid held high with two angles -> two core_start pulses, the second no earlier than two cycles after the first HOLD exit edge.
